cla_mod_sub_pipe: RTL
=====================

Name: cla_mod_sub_pipe

Overview:
- Pipelined modular subtractor: computes (a - b) mod MODULUS for NTT/FFT butterflies. It is the subtract-side counterpart of the carry-lookahead adder datapath.
- Stage 1 forms a - b using a hierarchical borrow-lookahead tree. Stage 2 adds MODULUS back when a borrow occurred.
- Valid/ready handshake on both sides, with full backpressure support. Throughput is one operation per cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, range 4..64.
- MODULUS, 12289, modulus; 1 < MODULUS < 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- in_a  input  WIDTH  minuend
- in_b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  (in_a - in_b) mod MODULUS
- range_err  output  1  qualified by out_valid; in_a or in_b was >= MODULUS

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_data=0, range_err=0.
  - All pipeline data registers are cleared to 0.
  - Reset mid-operation discards all in-flight results; nothing is emitted afterwards for them.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Pipeline control:
  - s2_adv = s1_valid & (~s2_valid | out_ready)
  - s1_adv = in_valid & (~s1_valid | s2_adv)
  - in_ready = ~s1_valid | s2_adv. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Stage 1 (registered on an input transfer):
  - Per-bit borrow generate g = ~a & b.
  - Per-bit borrow propagate p = ~(a ^ b).
  - 4-bit group lookahead, then a second lookahead level across groups (ripple between levels for WIDTH > 16).
  - Registers diff = a - b mod 2^WIDTH, borrow_out = (a < b), and err = (a >= MODULUS) | (b >= MODULUS).
- Stage 2 (registered on s2_adv):
  - out_data = borrow_out ? diff + MODULUS (mod 2^WIDTH) : diff.
  - range_err = err.
- Latency: exactly 2 cycles from input transfer to out_valid when no stall occurs.
- Stall behaviour:
  - While out_valid & ~out_ready, out_data and range_err stay stable.
  - Stage 1 holds if it is full; at most 2 results are in flight.
- Simultaneous events:
  - With both stages full and out_ready=1, an output transfer, an s1->s2 move and a new input transfer all occur in the same cycle.
  - No bubble is inserted, and ordering is strictly FIFO.
- Out-of-range operands:
  - Arithmetic is performed unchanged (a single conditional correction).
  - range_err=1 accompanies that result; no other side effect.
- Boundary cases:
  - a == b gives 0 with no correction.
  - a=0, b=MODULUS-1 gives 1.
  - No overflow is possible for in-range operands.

Decomposition:
- Shared package `mod_arith_pkg`:
  - WIDTH and MODULUS defaults.
  - Group size constant GRP=4.
  - Result typedef {data, err}.
- One sub-module, `cla16blg`: a 4-bit group borrow-lookahead generator.
  - Inputs: p/g for each of the 4 bits, plus b_in.
  - Outputs: 3 internal borrows, group g_out, group p_out.
  - Instantiated WIDTH/4 times, plus once more at the second level.

Test Plan (WIDTH=16, MODULUS=12289):
- Single op, out_ready=1: a=100, b=30 -> out_data=70 exactly 2 cycles later, range_err=0.
- Borrow path: a=5, b=10 -> 12284. Also a=0, b=12288 -> 1, and a=12288, b=0 -> 12288.
- Backpressure: stream 4 ops with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - out_data stays stable while stalled.
  - After release, all 4 results arrive in order with no loss or duplication.
- Full throughput: back-to-back ops, with out_ready=1 throughout and in_valid=1 for 1000 random in-range pairs.
  - One result per cycle, all matching the reference model.
- Range error: a=12289, b=1 -> range_err=1, out_data=12288. The next in-range op has range_err=0.
- Reset mid-stream: assert rst with both stages full.
  - The next cycle has out_valid=0 and out_data=0.
  - No stale results appear.
  - The first op after reset completes in 2 cycles.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular-arithmetic datapath blocks.
package mod_arith_pkg;
   localparam int unsigned     DEF_WIDTH   = 16;
   localparam longint unsigned DEF_MODULUS = 64'd12289;
   localparam int unsigned     GRP         = 4;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic                 err;
   } result_t;
endpackage

// File: rtl/cla16blg.sv
// 4-bit borrow-lookahead generator: internal borrows plus group generate/propagate.
module cla16blg (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       b_in,
   output logic [3:1] b_int,
   output logic       g_out,
   output logic       p_out
);
   assign b_int[1] = g[0] | (p[0] & b_in);
   assign b_int[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & b_in);
   assign b_int[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & b_in);
   assign g_out    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
   assign p_out    = &p;
endmodule

// File: rtl/cla_mod_sub_pipe.sv
// Two-stage pipelined (a - b) mod MODULUS: borrow-lookahead subtract, then conditional add-back.
module cla_mod_sub_pipe
   import mod_arith_pkg::*;
#(
   parameter int unsigned     WIDTH   = DEF_WIDTH,
   parameter longint unsigned MODULUS = DEF_MODULUS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             range_err
);
   localparam int unsigned     NG    = WIDTH / GRP;
   localparam int unsigned     NS    = (NG + 3) / 4;
   localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);

   logic [WIDTH-1:0]  p, g, bw;
   logic [NS*4-1:0]   gg, gp, gb;
   logic [NS-1:0]     sg, sp;
   logic [NS:0]       sb;
   logic [WIDTH-1:0]  diff;
   logic              borrow_out;

   assign p = ~(in_a ^ in_b);
   assign g = ~in_a & in_b;

   for (genvar j = 0; j < NG; j++) begin : g_grp
      cla16blg u_grp (
         .p     (p[4*j +: 4]),
         .g     (g[4*j +: 4]),
         .b_in  (gb[j]),
         .b_int (bw[4*j+1 +: 3]),
         .g_out (gg[j]),
         .p_out (gp[j])
      );
      assign bw[4*j] = gb[j];
   end

   // Unused group slots are made transparent (p=1, g=0) so the second level sees true group terms.
   for (genvar j = NG; j < NS*4; j++) begin : g_pad
      assign gg[j] = 1'b0;
      assign gp[j] = 1'b1;
   end

   assign sb[0] = 1'b0;
   for (genvar k = 0; k < NS; k++) begin : g_lvl2
      cla16blg u_lvl2 (
         .p     (gp[4*k +: 4]),
         .g     (gg[4*k +: 4]),
         .b_in  (sb[k]),
         .b_int (gb[4*k+1 +: 3]),
         .g_out (sg[k]),
         .p_out (sp[k])
      );
      assign gb[4*k]  = sb[k];
      assign sb[k+1]  = sg[k] | (sp[k] & sb[k]);
   end

   assign diff       = ~p ^ bw;
   assign borrow_out = sb[NS];

   logic             s1_valid, s2_valid;
   logic [WIDTH-1:0] s1_diff;
   logic             s1_borrow, s1_err;
   logic             s1_adv, s2_adv;

   assign s2_adv    = s1_valid & (~s2_valid | out_ready);
   assign s1_adv    = in_valid & (~s1_valid | s2_adv);
   assign in_ready  = ~s1_valid | s2_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_diff   <= '0;
         s1_borrow <= 1'b0;
         s1_err    <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid  <= 1'b1;
            s1_diff   <= diff;
            s1_borrow <= borrow_out;
            s1_err    <= (in_a >= MOD_W) | (in_b >= MOD_W);
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         out_data  <= '0;
         range_err <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid  <= 1'b1;
            out_data  <= s1_borrow ? (s1_diff + MOD_W) : s1_diff;
            range_err <= s1_err;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end
endmodule
